// File: rtl/fetch_sequencer.sv
// Instruction-fetch and phase sequencer: PC/IR, imem handshake, FETCH->ISSUE->EXECUTE.
// Optional single-step input STEP is enabled by defining FETCH_SINGLE_STEP_EN.
module fetch_sequencer #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              EXEC,
`ifdef FETCH_SINGLE_STEP_EN
    input  logic              STEP,
`endif
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic [15:0]       IMEM_RDATA,
    input  logic              IMEM_VALID,
    input  logic              PC_load,
    input  logic [ADDR_W-1:0] BRANCH_TARGET,
    output logic [15:0]       COMMAND,
    output logic [ADDR_W-1:0] PC,
    output logic              EXEC_PHASE,
    output logic              RUNNING,
    output logic              FETCH_ERR,
    output logic [15:0]       INSTR_COUNT
);

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned INSTR_W = 16;

    typedef enum logic [1:0] {
        HALT,
        FETCH,
        ISSUE,
        EXECUTE
    } state_t;

    state_t              state;
    logic                stop_pending;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [2:0]          exec_sync;
    logic                exec_pulse;
    logic                is_hlt;

    // Two-flop synchroniser plus one history flop for rising-edge detect
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            exec_sync <= 3'b000;
        end else begin
            exec_sync <= {exec_sync[1:0], EXEC};
        end
    end

    assign exec_pulse = exec_sync[1] & ~exec_sync[2];

`ifdef FETCH_SINGLE_STEP_EN
    logic [2:0] step_sync;
    logic       step_pulse;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            step_sync <= 3'b000;
        end else begin
            step_sync <= {step_sync[1:0], STEP};
        end
    end

    assign step_pulse = step_sync[1] & ~step_sync[2];
`endif

    assign is_hlt    = (COMMAND[15:14] == 2'b11) && (COMMAND[7:4] == 4'hF);
    assign IMEM_ADDR = PC;

    // Phase FSM; every output is updated alongside the state it belongs to
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state        <= HALT;
            PC           <= '0;
            COMMAND      <= '0;
            IMEM_REQ     <= 1'b0;
            EXEC_PHASE   <= 1'b0;
            RUNNING      <= 1'b0;
            FETCH_ERR    <= 1'b0;
            INSTR_COUNT  <= '0;
            stop_pending <= 1'b0;
            wait_cnt     <= '0;
        end else begin
            case (state)
                HALT: begin
                    if (exec_pulse) begin
                        state        <= FETCH;
                        IMEM_REQ     <= 1'b1;
                        RUNNING      <= 1'b1;
                        FETCH_ERR    <= 1'b0;
                        stop_pending <= 1'b0;
                        wait_cnt     <= '0;
                    end
`ifdef FETCH_SINGLE_STEP_EN
                    else if (step_pulse) begin
                        // A single step is a run that is already asked to stop
                        state        <= FETCH;
                        IMEM_REQ     <= 1'b1;
                        RUNNING      <= 1'b1;
                        FETCH_ERR    <= 1'b0;
                        stop_pending <= 1'b1;
                        wait_cnt     <= '0;
                    end
`endif
                end
                FETCH: begin
                    if (IMEM_VALID) begin
                        COMMAND  <= IMEM_RDATA;
                        state    <= ISSUE;
                        IMEM_REQ <= 1'b0;
                        if (exec_pulse) stop_pending <= 1'b1;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        // Timeout takes priority over a coincident stop request
                        FETCH_ERR <= 1'b1;
                        state     <= HALT;
                        IMEM_REQ  <= 1'b0;
                        RUNNING   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                        if (exec_pulse) stop_pending <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_pulse) stop_pending <= 1'b1;
                    if (is_hlt) begin
                        state       <= HALT;
                        RUNNING     <= 1'b0;
                        INSTR_COUNT <= INSTR_COUNT + INSTR_W'(1);
                    end else begin
                        state      <= EXECUTE;
                        EXEC_PHASE <= 1'b1;
                    end
                end
                EXECUTE: begin
                    PC          <= PC_load ? BRANCH_TARGET : PC + ADDR_W'(1);
                    INSTR_COUNT <= INSTR_COUNT + INSTR_W'(1);
                    EXEC_PHASE  <= 1'b0;
                    if (stop_pending || exec_pulse) begin
                        state   <= HALT;
                        RUNNING <= 1'b0;
                    end else begin
                        state    <= FETCH;
                        IMEM_REQ <= 1'b1;
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: memory model with per-address wait
// states, scoreboard of fetched words compared in EXECUTE, directed scenarios.
module tb_fetch_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        EXEC;
    logic        IMEM_REQ;
    logic [15:0] IMEM_ADDR;
    logic [15:0] IMEM_RDATA;
    logic        IMEM_VALID;
    logic        PC_load;
    logic [15:0] BRANCH_TARGET;
    logic [15:0] COMMAND;
    logic [15:0] PC;
    logic        EXEC_PHASE;
    logic        RUNNING;
    logic        FETCH_ERR;
    logic [15:0] INSTR_COUNT;
`ifdef FETCH_SINGLE_STEP_EN
    logic        STEP;
`endif

    fetch_sequencer dut (
        .CLOCK        (CLOCK),
        .RESET        (RESET),
        .EXEC         (EXEC),
`ifdef FETCH_SINGLE_STEP_EN
        .STEP         (STEP),
`endif
        .IMEM_REQ     (IMEM_REQ),
        .IMEM_ADDR    (IMEM_ADDR),
        .IMEM_RDATA   (IMEM_RDATA),
        .IMEM_VALID   (IMEM_VALID),
        .PC_load      (PC_load),
        .BRANCH_TARGET(BRANCH_TARGET),
        .COMMAND      (COMMAND),
        .PC           (PC),
        .EXEC_PHASE   (EXEC_PHASE),
        .RUNNING      (RUNNING),
        .FETCH_ERR    (FETCH_ERR),
        .INSTR_COUNT  (INSTR_COUNT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [15:0] mem [0:255];
    int          wait_tab [0:255];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          mcnt     = 0;
    int          last_fetch_cyc = 0;
    bit          have_last  = 0;
    bit          period_chk = 0;
    bit          branch_en  = 0;
    bit          glitch_en  = 0;
    bit          stray_en   = 0;
    bit          resp_prev  = 0;
    logic [15:0] branch_at     = 16'h0002;
    logic [15:0] branch_target = 16'h0020;
    logic [15:0] exp_pc    = 16'h0000;
    logic [15:0] exp_count = 16'h0000;
    logic [15:0] cmd_hold  = 16'h0000;
    logic [15:0] rdata_prev = 16'h0000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_hlt_word(input logic [15:0] w);
        return (w[15:14] == 2'b11) && (w[7:4] == 4'hF);
    endfunction

    // Instruction memory: answers after wait_tab[addr] request cycles
    always @(posedge CLOCK) begin
        #1;
        cyc++;
        if (resp_prev) begin
            cmd_hold  = rdata_prev;
            resp_prev = 0;
        end
        if (IMEM_REQ) begin
            if (mcnt == wait_tab[IMEM_ADDR[7:0]]) begin
                IMEM_VALID = 1'b1;
                IMEM_RDATA = mem[IMEM_ADDR[7:0]];
                check("fetch_addr", 32'(IMEM_ADDR), 32'(exp_pc));
                if (period_chk && have_last) check("fetch_period", 32'(cyc - last_fetch_cyc), 32'd3);
                last_fetch_cyc = cyc;
                have_last      = 1;
                exp_count      = exp_count + 16'd1;
                resp_prev      = 1;
                rdata_prev     = IMEM_RDATA;
                if (is_hlt_word(IMEM_RDATA)) begin
                    exp_pc = IMEM_ADDR;
                end else begin
                    sb.push_back('{addr: IMEM_ADDR, data: IMEM_RDATA});
                    exp_pc = (branch_en && IMEM_ADDR == branch_at) ? branch_target : IMEM_ADDR + 16'd1;
                end
            end else begin
                IMEM_VALID = 1'b0;
                IMEM_RDATA = 16'($urandom);
            end
            mcnt++;
        end else begin
            mcnt       = 0;
            IMEM_VALID = stray_en ? 1'b1 : 1'b0;
            IMEM_RDATA = 16'($urandom);
        end
    end

    // EXECUTE-phase scoreboard, COMMAND hold check and PC_load driver
    always @(negedge CLOCK) begin
        PC_load       = 1'b0;
        BRANCH_TARGET = 16'h00AA;
        if (RESET && EXEC_PHASE) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("exe_pc", 32'(PC), 32'(e.addr));
                check("exe_cmd", 32'(COMMAND), 32'(e.data));
                if (branch_en && e.addr == branch_at) begin
                    PC_load       = 1'b1;
                    BRANCH_TARGET = branch_target;
                end
            end
        end else if (RESET && IMEM_REQ) begin
            check("hold_cmd", 32'(COMMAND), 32'(cmd_hold));
            if (glitch_en) begin
                PC_load       = 1'b1;
                BRANCH_TARGET = 16'h0099;
            end
        end
    end

    task automatic mem_default();
        for (int i = 0; i < 256; i++) begin
            mem[i]      = 16'hC000;
            wait_tab[i] = 0;
        end
    endtask

    task automatic clear_model();
        sb.delete();
        exp_pc     = 16'h0000;
        exp_count  = 16'h0000;
        cmd_hold   = 16'h0000;
        resp_prev  = 0;
        have_last  = 0;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b0;
        repeat (2) @(negedge CLOCK);
        clear_model();
        RESET = 1'b1;
        @(negedge CLOCK);
    endtask

    task automatic press_exec();
        @(negedge CLOCK);
        EXEC = 1'b1;
        @(negedge CLOCK);
        EXEC = 1'b0;
    endtask

    task automatic wait_running(input string tag, input logic val);
        int n = 0;
        while (RUNNING !== val && n < 300) begin
            @(negedge CLOCK);
            n++;
        end
        check(tag, 32'(RUNNING), 32'(val));
    endtask

    task automatic wait_fetch(input string tag, input logic [15:0] addr);
        int n = 0;
        while (!(IMEM_REQ === 1'b1 && IMEM_ADDR === addr) && n < 300) begin
            @(negedge CLOCK);
            n++;
        end
        check(tag, 32'(IMEM_ADDR), 32'(addr));
    endtask

    task automatic check_halted(input string tag, input logic [15:0] pc_exp);
        check({tag, "_pc"}, 32'(PC), 32'(pc_exp));
        check({tag, "_count"}, 32'(INSTR_COUNT), 32'(exp_count));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check({tag, "_req"}, 32'(IMEM_REQ), 32'd0);
    endtask

    initial begin
        RESET         = 1'b0;
        EXEC          = 1'b0;
        PC_load       = 1'b0;
        BRANCH_TARGET = 16'h0000;
        IMEM_VALID    = 1'b0;
        IMEM_RDATA    = 16'h0000;
`ifdef FETCH_SINGLE_STEP_EN
        STEP          = 1'b0;
`endif
        mem_default();
        repeat (3) @(negedge CLOCK);
        clear_model();
        RESET = 1'b1;
        @(negedge CLOCK);
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_cmd", 32'(COMMAND), 32'd0);
        check("rst_running", 32'(RUNNING), 32'd0);
        check("rst_count", 32'(INSTR_COUNT), 32'd0);
        check("rst_err", 32'(FETCH_ERR), 32'd0);
        check("rst_phase", 32'(EXEC_PHASE), 32'd0);

        // Reset asserted mid-FETCH at PC=5 drops the request immediately
        wait_tab[5] = 12;
        press_exec();
        wait_fetch("rstf_reach5", 16'h0005);
        RESET = 1'b0;
        #1;
        check("rstf_req", 32'(IMEM_REQ), 32'd0);
        check("rstf_running", 32'(RUNNING), 32'd0);
        @(negedge CLOCK);
        clear_model();
        RESET = 1'b1;
        @(negedge CLOCK);
        check("rstf_pc", 32'(PC), 32'd0);
        check("rstf_cmd", 32'(COMMAND), 32'd0);
        check("rstf_running2", 32'(RUNNING), 32'd0);
        check("rstf_count", 32'(INSTR_COUNT), 32'd0);

        // Straight-line run at zero wait states ending in HLT at address 4
        mem_default();
        mem[4]     = 16'hC0F0;
        period_chk = 1;
        press_exec();
        wait_running("run_start", 1'b1);
        wait_running("run_halt", 1'b0);
        period_chk = 0;
        check_halted("run", 16'h0004);
        check("run_count5", 32'(INSTR_COUNT), 32'd5);
        check("run_cmd_hlt", 32'(COMMAND), 32'h0000C0F0);

        // Branch in EXECUTE of address 2, PC_load glitches in FETCH, stray VALID
        do_reset();
        mem_default();
        mem[16'h20] = 16'hC0F0;
        mem[16'h99] = 16'hC0F0;
        branch_en = 1;
        glitch_en = 1;
        stray_en  = 1;
        press_exec();
        wait_running("br_start", 1'b1);
        wait_running("br_halt", 1'b0);
        branch_en = 0;
        glitch_en = 0;
        stray_en  = 0;
        check_halted("br", 16'h0020);
        check("br_count4", 32'(INSTR_COUNT), 32'd4);

        // 14-wait fetch succeeds, 15-wait fetch times out, next start clears the flag
        do_reset();
        mem_default();
        mem[2]      = 16'hC0F0;
        wait_tab[0] = 14;
        wait_tab[1] = 15;
        press_exec();
        wait_running("to_start", 1'b1);
        wait_running("to_halt", 1'b0);
        check("to_err", 32'(FETCH_ERR), 32'd1);
        check_halted("to", 16'h0001);
        wait_tab[1] = 0;
        press_exec();
        wait_running("to_restart", 1'b1);
        check("to_err_clr", 32'(FETCH_ERR), 32'd0);
        wait_running("to_halt2", 1'b0);
        check("to_err_clr2", 32'(FETCH_ERR), 32'd0);
        check_halted("to2", 16'h0002);

        // Stop request landing in ISSUE of address 7, then resume at 8
        do_reset();
        mem_default();
        mem[9]      = 16'hC0F0;
        wait_tab[7] = 10;
        press_exec();
        wait_fetch("stop_reach7", 16'h0007);
        repeat (8) @(negedge CLOCK);
        press_exec();
        wait_running("stop_halt", 1'b0);
        check_halted("stop", 16'h0008);
        check("stop_count8", 32'(INSTR_COUNT), 32'd8);
        press_exec();
        wait_running("resume_start", 1'b1);
        wait_running("resume_halt", 1'b0);
        check_halted("resume", 16'h0009);
        check("resume_count", 32'(INSTR_COUNT), 32'd10);

`ifdef FETCH_SINGLE_STEP_EN
        // Three single steps from PC=0
        do_reset();
        mem_default();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLOCK);
            STEP = 1'b1;
            @(negedge CLOCK);
            STEP = 1'b0;
            wait_running("step_start", 1'b1);
            wait_running("step_halt", 1'b0);
            repeat (2) @(negedge CLOCK);
            check("step_idle", 32'(RUNNING), 32'd0);
            check_halted("step", 16'(i + 1));
        end
        check("step_count3", 32'(INSTR_COUNT), 32'd3);
`endif

        repeat (3) @(negedge CLOCK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch and phase sequencer directly upstream of the control unit.
- Holds PC and the instruction register (IR), fetches from instruction memory with a req/valid handshake, and drives COMMAND to the control unit.
- Steps each instruction through FETCH -> ISSUE -> EXECUTE and applies the control unit's registered PC_load.
- EXEC push-button starts and stops the machine; a HLT opcode also halts it.

Parameters:
- ADDR_W, 16, PC / instruction address width.
- TIMEOUT, 15, maximum FETCH wait cycles before a fetch error (1..255).

Ports:
- CLOCK  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-low reset.
- EXEC  in  1  raw run/stop push-button; asynchronous to CLOCK.
- IMEM_REQ  out  1  fetch request to instruction memory.
- IMEM_ADDR  out  ADDR_W  fetch address; equals PC.
- IMEM_RDATA  in  16  instruction word.
- IMEM_VALID  in  1  IMEM_RDATA valid this cycle.
- PC_load  in  1  branch taken, from control unit; sampled in EXECUTE only.
- BRANCH_TARGET  in  ADDR_W  branch destination, from the datapath.
- COMMAND  out  16  IR contents to control unit.
- PC  out  ADDR_W  current PC.
- EXEC_PHASE  out  1  high during EXECUTE; qualifies register-file/memory writes.
- RUNNING  out  1  high in any state except HALT.
- FETCH_ERR  out  1  sticky fetch-timeout flag.
- INSTR_COUNT  out  16  retired-instruction count; wraps.

Behaviour:
- Reset (RESET=0, asynchronous): state=HALT, PC=0, COMMAND=0, IMEM_REQ=0, EXEC_PHASE=0, FETCH_ERR=0, INSTR_COUNT=0, stop_pending=0, EXEC synchroniser cleared.
  - Reset during FETCH drops IMEM_REQ in the same cycle; no partial IR load.
- EXEC input: 2-flop synchroniser, then rising-edge detect. exec_pulse is one cycle wide, 3 cycles after the EXEC rise.
- States:
  - HALT:
    - IMEM_REQ=0.
    - exec_pulse -> FETCH; clears FETCH_ERR and stop_pending.
  - FETCH:
    - IMEM_REQ=1, IMEM_ADDR=PC; wait counter increments each cycle.
    - IMEM_VALID=1 -> IR<=IMEM_RDATA, go to ISSUE. IMEM_VALID in the first FETCH cycle is legal (0 wait).
    - TIMEOUT cycles elapse without IMEM_VALID -> FETCH_ERR<=1, go to HALT; PC unchanged.
  - ISSUE:
    - One cycle; COMMAND stable; control unit registers its outputs at the end of this cycle.
    - If IR is HLT (IR[15:14]=2'b11 and IR[7:4]=4'b1111) -> HALT. PC is not advanced; INSTR_COUNT+1.
  - EXECUTE:
    - One cycle; EXEC_PHASE=1.
    - PC <= PC_load ? BRANCH_TARGET : PC+1, using ADDR_W-bit wrap (0xFFFF+1 -> 0x0000).
    - INSTR_COUNT <= INSTR_COUNT+1.
    - Next state: stop_pending ? HALT : FETCH.
- Stop request: exec_pulse in FETCH, ISSUE or EXECUTE sets stop_pending.
  - The current instruction completes; halt occurs after its EXECUTE.
  - exec_pulse and timeout in the same cycle: the timeout wins.
- Timing:
  - COMMAND changes only on the ISSUE entry edge and is held through EXECUTE and the next FETCH.
  - Minimum instruction time: 3 cycles (0-wait memory).
- PC_load and BRANCH_TARGET are ignored outside EXECUTE.
- IMEM_VALID outside FETCH is ignored.

Optional Feature:
- Macro: FETCH_SINGLE_STEP_EN.
- When defined:
  - Adds input STEP (1 bit, synchronised and edge-detected like EXEC).
  - STEP pulse in HALT runs exactly one instruction (FETCH/ISSUE/EXECUTE), then returns to HALT. This is implemented by setting stop_pending on entry.
  - STEP while RUNNING is ignored. STEP and EXEC pulses in the same HALT cycle: EXEC wins (free run).
- When not defined: no STEP port; behaviour exactly as above.

Test Plan:
- Reset with PC=0x0005, in FETCH -> IMEM_REQ=0 immediately; after release PC=0, COMMAND=0, RUNNING=0, INSTR_COUNT=0.
- EXEC pulse, 0-wait memory returning 0xC000 at addresses 0..3, then HLT 0xC0F0 at 4:
  - PC steps 0,1,2,3,4 every 3 cycles.
  - Halts with PC=4, INSTR_COUNT=5.
- Branch: PC_load=1 with BRANCH_TARGET=0x0020 in the EXECUTE of address 2 -> next IMEM_ADDR=0x0020.
  - PC_load=1 pulsed during FETCH -> no effect.
- Memory holding IMEM_VALID low for 15 cycles -> FETCH_ERR=1, HALT, PC unchanged.
  - A 14-cycle wait completes normally.
  - Next EXEC pulse clears FETCH_ERR.
- EXEC pressed during ISSUE of address 7 -> address 7 completes, halt with PC=8.
  - Second EXEC press resumes fetch at 8.
- FETCH_SINGLE_STEP_EN build: three STEP pulses from PC=0 -> PC=3, INSTR_COUNT=3, RUNNING low between steps.
